mips_multicycle_ctrl: RTL and testbench

//   Multi-cycle MIPS control FSM sitting directly upstream of the ALU. Decodes the latched

---
 rtl/mips_pkg.sv | 58 +++++
 rtl/mips_multicycle_ctrl_if.sv | 41 ++++
 rtl/mips_mem_wait_timer.sv | 24 ++
 rtl/mips_multicycle_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 266 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared encodings for the multi-cycle MIPS controller: ALU ops, opcodes, functs,
// operand-mux selects and the controller state enum.
package mips_pkg;

  localparam logic [2:0] A_NOP = 3'd0;
  localparam logic [2:0] A_ADD = 3'd1;
  localparam logic [2:0] A_SUB = 3'd2;
  localparam logic [2:0] A_AND = 3'd3;
  localparam logic [2:0] A_OR  = 3'd4;
  localparam logic [2:0] A_XOR = 3'd5;
  localparam logic [2:0] A_NOR = 3'd6;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [1:0] PC_ALU = 2'd0;
  localparam logic [1:0] PC_BRT = 2'd1;
  localparam logic [1:0] PC_JMP = 2'd2;

  localparam logic [1:0] SRCB_RT     = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  typedef enum logic [3:0] {
    S_RST, S_IF, S_ID, S_EXR, S_EXI, S_WBR, S_WBI,
    S_ADR, S_MRD, S_WBM, S_MWR, S_BR, S_JMP
  } state_t;

  // Unsupported functs map to A_NOP, which the FSM treats as illegal.
  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      FN_ADD:  return A_ADD;
      FN_SUB:  return A_SUB;
      FN_AND:  return A_AND;
      FN_OR:   return A_OR;
      FN_XOR:  return A_XOR;
      FN_NOR:  return A_NOR;
      default: return A_NOP;
    endcase
  endfunction

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Controller <-> datapath/memory signal bundle; master is the controller side.
interface mips_multicycle_ctrl_if;
  import mips_pkg::*;

  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       overflow;
  // Handshake: mem_re/mem_we act as valid and stay high until the cycle mem_ready
  // (ready) is seen; a transfer completes only in a cycle where both are high.
  logic       mem_ready;
  logic       pc_we;
  logic [1:0] pc_src;
  logic       iord;
  logic       mem_re;
  logic       mem_we;
  logic       ir_we;
  logic       reg_we;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       ext_zero;
  logic [2:0] alu_op;
  logic       illegal;
  logic       ovf_trap;
  logic       bus_err;
  state_t     dbg_state;

  modport master (
    input  opcode, funct, zero, overflow, mem_ready,
    output pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, ext_zero, alu_op, illegal, ovf_trap, bus_err, dbg_state
  );

  modport slave (
    output opcode, funct, zero, overflow, mem_ready,
    input  pc_we, pc_src, iord, mem_re, mem_we, ir_we, reg_we, reg_dst, mem_to_reg,
           alu_src_a, alu_src_b, ext_zero, alu_op, illegal, ovf_trap, bus_err, dbg_state
  );
endinterface

// File: rtl/mips_mem_wait_timer.sv
// Memory wait-state counter; flags timeout on the last allowed waiting cycle.
module mips_mem_wait_timer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic busy,
  input  logic ready,
  output logic timeout
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || start || ready || !busy) cnt <= '0;
    else                                   cnt <= cnt + 1'b1;
  end

  // cnt counts completed waits, so the MEM_TIMEOUT-th waiting cycle sees MEM_TIMEOUT-1.
  assign timeout = busy && !ready && (cnt == CNT_W'(MEM_TIMEOUT - 1));

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback and
// drives datapath strobes, mux selects and alu_op, plus trap/error pulses.
module mips_multicycle_ctrl
  import mips_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input logic                    clk,
  input logic                    rst_n,
  mips_multicycle_ctrl_if.master bus
);

  state_t     state, state_n;
  logic       illegal_q, ovf_q, bus_err_q;
  logic       illegal_n, ovf_n, bus_err_n;
  logic       busy, start, timeout;
  logic [2:0] fn_op;

  assign fn_op = funct_alu(bus.funct);
  assign busy  = (state == S_IF) || (state == S_MRD) || (state == S_MWR);
  // Counter restarts on every state change and on a timeout that re-enters IF.
  assign start = (state_n != state) || bus_err_n;

  mips_mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .busy    (busy),
    .ready   (bus.mem_ready),
    .timeout (timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_RST;
      illegal_q <= 1'b0;
      ovf_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      state     <= state_n;
      illegal_q <= illegal_n;
      ovf_q     <= ovf_n;
      bus_err_q <= bus_err_n;
    end
  end

  always_comb begin
    state_n        = state;
    illegal_n      = 1'b0;
    ovf_n          = 1'b0;
    bus_err_n      = 1'b0;
    bus.pc_we      = 1'b0;
    bus.pc_src     = PC_ALU;
    bus.iord       = 1'b0;
    bus.mem_re     = 1'b0;
    bus.mem_we     = 1'b0;
    bus.ir_we      = 1'b0;
    bus.reg_we     = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.alu_src_a  = 1'b0;
    bus.alu_src_b  = SRCB_RT;
    bus.ext_zero   = 1'b0;
    bus.alu_op     = A_NOP;
    case (state)
      S_RST: state_n = S_IF;
      S_IF: begin
        bus.mem_re = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_we     = 1'b1;
          bus.pc_we     = 1'b1;
          bus.alu_src_b = SRCB_FOUR;
          bus.alu_op    = A_ADD;
          state_n       = S_ID;
        end else if (timeout) begin
          bus_err_n = 1'b1;
          state_n   = S_IF;
        end
      end
      S_ID: begin
        bus.alu_src_b = SRCB_IMM_SH;
        bus.alu_op    = A_ADD;
        case (bus.opcode)
          OP_RTYPE:                         state_n = S_EXR;
          OP_ADDI, OP_ANDI, OP_ORI, OP_XORI: state_n = S_EXI;
          OP_LW, OP_SW:                     state_n = S_ADR;
          OP_BEQ, OP_BNE:                   state_n = S_BR;
          OP_J:                             state_n = S_JMP;
          default: begin
            illegal_n = 1'b1;
            state_n   = S_IF;
          end
        endcase
      end
      S_EXR: begin
        bus.alu_src_a = 1'b1;
        if (fn_op != A_NOP) begin
          bus.alu_op = fn_op;
          ovf_n      = bus.overflow && ((fn_op == A_ADD) || (fn_op == A_SUB));
          state_n    = S_WBR;
        end else begin
          illegal_n = 1'b1;
          state_n   = S_IF;
        end
      end
      S_EXI: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        case (bus.opcode)
          OP_ADDI: begin
            bus.alu_op = A_ADD;
            ovf_n      = bus.overflow;
          end
          OP_ANDI: begin bus.alu_op = A_AND; bus.ext_zero = 1'b1; end
          OP_ORI:  begin bus.alu_op = A_OR;  bus.ext_zero = 1'b1; end
          OP_XORI: begin bus.alu_op = A_XOR; bus.ext_zero = 1'b1; end
          default: bus.alu_op = A_NOP;
        endcase
        state_n = S_WBI;
      end
      // ovf_q is the trap pulse itself, so it also gates the writeback it cancels.
      S_WBR: begin
        bus.reg_we  = !ovf_q;
        bus.reg_dst = 1'b1;
        state_n     = S_IF;
      end
      S_WBI: begin
        bus.reg_we = !ovf_q;
        state_n    = S_IF;
      end
      S_ADR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_op    = A_ADD;
        state_n       = (bus.opcode == OP_SW) ? S_MWR : S_MRD;
      end
      S_MRD: begin
        bus.iord   = 1'b1;
        bus.mem_re = 1'b1;
        if (bus.mem_ready) state_n = S_WBM;
        else if (timeout) begin
          bus_err_n = 1'b1;
          state_n   = S_IF;
        end
      end
      S_WBM: begin
        bus.reg_we     = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_n        = S_IF;
      end
      S_MWR: begin
        bus.iord   = 1'b1;
        bus.mem_we = 1'b1;
        if (bus.mem_ready) state_n = S_IF;
        else if (timeout) begin
          bus_err_n = 1'b1;
          state_n   = S_IF;
        end
      end
      S_BR: begin
        bus.alu_src_a = 1'b1;
        bus.alu_op    = A_SUB;
        bus.pc_src    = PC_BRT;
        bus.pc_we     = ((bus.opcode == OP_BEQ) && bus.zero) ||
                        ((bus.opcode == OP_BNE) && !bus.zero);
        state_n       = S_IF;
      end
      S_JMP: begin
        bus.pc_we  = 1'b1;
        bus.pc_src = PC_JMP;
        state_n    = S_IF;
      end
      default: state_n = S_RST;
    endcase
  end

  assign bus.illegal   = illegal_q;
  assign bus.ovf_trap  = ovf_q;
  assign bus.bus_err   = bus_err_q;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: walks each instruction class through the FSM
// and compares strobes, selects and pulses against hand-computed values.
module tb_mips_multicycle_ctrl;
  import mips_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [3:0] exp_q[$];

  mips_multicycle_ctrl_if bus();

  mips_multicycle_ctrl #(.MEM_TIMEOUT(15), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs change just after this returns; checks follow a further #1.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [19:0] outs();
    return {bus.pc_we, bus.pc_src, bus.iord, bus.mem_re, bus.mem_we, bus.ir_we,
            bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b,
            bus.ext_zero, bus.alu_op, bus.illegal, bus.ovf_trap, bus.bus_err};
  endfunction

  task automatic pop_state(input string tag);
    logic [3:0] e;
    e = exp_q.pop_front();
    check(tag, 32'(bus.dbg_state), 32'(e));
  endtask

  // Sitting in IF: present the instruction with mem_ready, land in ID.
  task automatic fetch(input string tag, input logic [5:0] op, input logic [5:0] fn);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = 1'b1;
    #1;
    check({tag, "_if_state"}, 32'(bus.dbg_state), 32'(S_IF));
    check({tag, "_if_strobes"}, {bus.ir_we, bus.pc_we, bus.pc_src, bus.alu_src_a,
          bus.alu_src_b, bus.alu_op}, {1'b1, 1'b1, 2'd0, 1'b0, 2'd1, 3'd1});
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check({tag, "_id_state"}, 32'(bus.dbg_state), 32'(S_ID));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_we;
    int n_be;
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    bus.opcode    = 6'h00;
    bus.funct     = 6'h00;
    bus.zero      = 1'b0;
    bus.overflow  = 1'b0;
    bus.mem_ready = 1'b0;

    // Reset
    repeat (3) cyc();
    #1;
    check("rst_outs", 32'(outs()), 32'h0);
    check("rst_state", 32'(bus.dbg_state), 32'(S_RST));
    rst_n = 1'b1;
    #1;
    check("rst_rel_mem_re", 32'(bus.mem_re), 32'h0);
    cyc();
    #1;
    check("rst_if_mem_re", 32'(bus.mem_re), 32'h1);
    check("rst_if_iord", 32'(bus.iord), 32'h0);

    // add: IF, ID, EXR, WBR, back to IF
    exp_q = '{4'(S_EXR), 4'(S_WBR), 4'(S_IF)};
    fetch("add", OP_RTYPE, FN_ADD);
    check("add_id_mux", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, {1'b0, 2'd3, 3'd1});
    cyc(); #1;
    pop_state("add_exr_state");
    check("add_exr", {bus.alu_src_a, bus.alu_src_b, bus.alu_op}, {1'b1, 2'd0, 3'd1});
    cyc(); #1;
    pop_state("add_wbr_state");
    check("add_wbr", {bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.ovf_trap},
          {1'b1, 1'b1, 1'b0, 1'b0});
    cyc(); #1;
    pop_state("add_done_state");

    // sub with overflow: writeback suppressed, trap pulses once
    fetch("sub", OP_RTYPE, FN_SUB);
    cyc();
    bus.overflow = 1'b1;
    #1;
    check("sub_exr_op", 32'(bus.alu_op), 32'd2);
    cyc();
    bus.overflow = 1'b0;
    #1;
    check("sub_wbr", {bus.reg_we, bus.ovf_trap}, {1'b0, 1'b1});
    cyc(); #1;
    check("sub_trap_clear", {bus.ovf_trap, 4'(bus.dbg_state)}, {1'b0, 4'(S_IF)});

    // and with overflow: logical op ignores the flag
    fetch("and", OP_RTYPE, FN_AND);
    cyc();
    bus.overflow = 1'b1;
    #1;
    check("and_exr_op", 32'(bus.alu_op), 32'd3);
    cyc();
    bus.overflow = 1'b0;
    #1;
    check("and_wbr", {bus.reg_we, bus.ovf_trap}, {1'b1, 1'b0});
    cyc();

    // nor and bad funct
    fetch("nor", OP_RTYPE, FN_NOR);
    cyc(); #1;
    check("nor_exr_op", 32'(bus.alu_op), 32'd6);
    cyc(); cyc();
    fetch("badfn", OP_RTYPE, 6'h3F);
    cyc(); #1;
    check("badfn_exr", 32'(bus.reg_we), 32'h0);
    cyc(); #1;
    check("badfn_illegal", {bus.illegal, 4'(bus.dbg_state), bus.reg_we}, {1'b1, 4'(S_IF), 1'b0});

    // beq taken
    fetch("beq", OP_BEQ, 6'h00);
    cyc();
    bus.zero = 1'b1;
    #1;
    check("beq_br", {bus.alu_src_a, bus.alu_op, bus.pc_we, bus.pc_src},
          {1'b1, 3'd2, 1'b1, 2'd1});
    cyc();

    // bne with zero=1 not taken; with zero=0 taken
    fetch("bne", OP_BNE, 6'h00);
    cyc(); #1;
    check("bne_z1", {bus.pc_we, bus.pc_src}, {1'b0, 2'd1});
    bus.zero = 1'b0;
    #1;
    check("bne_z0", 32'(bus.pc_we), 32'h1);
    cyc();

    // j
    fetch("j", OP_J, 6'h00);
    cyc(); #1;
    check("j_jmp", {bus.pc_we, bus.pc_src, bus.reg_we, bus.mem_we}, {1'b1, 2'd2, 1'b0, 1'b0});
    cyc();

    // lw with three wait cycles
    fetch("lw", OP_LW, 6'h00);
    cyc(); #1;
    check("lw_adr", {bus.alu_src_a, bus.alu_src_b, bus.ext_zero, bus.alu_op},
          {1'b1, 2'd2, 1'b0, 3'd1});
    cyc();
    n_we = 0;
    for (int i = 0; i < 3; i++) begin
      #1;
      if (bus.mem_re && bus.iord && bus.dbg_state == S_MRD) n_we++;
      cyc();
    end
    check("lw_wait_cycles", 32'(n_we), 32'd3);
    bus.mem_ready = 1'b1;
    #1;
    check("lw_mrd_ready", {bus.mem_re, bus.iord}, {1'b1, 1'b1});
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("lw_wbm", {bus.reg_we, bus.reg_dst, bus.mem_to_reg, bus.mem_re},
          {1'b1, 1'b0, 1'b1, 1'b0});
    cyc();

    // sw: mem_ready on the 15th wait cycle wins over the timeout
    fetch("swok", OP_SW, 6'h00);
    cyc(); cyc();
    repeat (14) cyc();
    bus.mem_ready = 1'b1;
    #1;
    check("swok_last", {bus.mem_we, 4'(bus.dbg_state)}, {1'b1, 4'(S_MWR)});
    cyc();
    bus.mem_ready = 1'b0;
    #1;
    check("swok_done", {bus.bus_err, 4'(bus.dbg_state)}, {1'b0, 4'(S_IF)});

    // sw timeout: 15 write-strobe cycles, then bus_err in IF
    fetch("swto", OP_SW, 6'h00);
    cyc(); cyc();
    n_we = 0;
    n_be = 0;
    for (int i = 0; i < 15; i++) begin
      #1;
      if (bus.mem_we) n_we++;
      if (bus.bus_err) n_be++;
      cyc();
    end
    check("swto_we_cycles", 32'(n_we), 32'd15);
    check("swto_early_err", 32'(n_be), 32'd0);
    #1;
    check("swto_err", {bus.bus_err, bus.mem_we, bus.pc_we, 4'(bus.dbg_state)},
          {1'b1, 1'b0, 1'b0, 4'(S_IF)});
    cyc(); #1;
    check("swto_err_clear", 32'(bus.bus_err), 32'h0);

    // addi with overflow
    fetch("addi", OP_ADDI, 6'h00);
    cyc();
    bus.overflow = 1'b1;
    #1;
    check("addi_exi", {bus.alu_src_a, bus.alu_src_b, bus.ext_zero, bus.alu_op},
          {1'b1, 2'd2, 1'b0, 3'd1});
    cyc();
    bus.overflow = 1'b0;
    #1;
    check("addi_wbi", {bus.reg_we, bus.reg_dst, bus.ovf_trap}, {1'b0, 1'b0, 1'b1});
    cyc();

    // ori: zero-extended OR, normal writeback
    fetch("ori", OP_ORI, 6'h00);
    cyc(); #1;
    check("ori_exi", {bus.ext_zero, bus.alu_op}, {1'b1, 3'd4});
    cyc(); #1;
    check("ori_wbi", {bus.reg_we, bus.reg_dst, bus.ovf_trap}, {1'b1, 1'b0, 1'b0});
    cyc();

    // illegal opcode
    fetch("bad", 6'h3F, 6'h00);
    cyc(); #1;
    check("bad_illegal", {bus.illegal, 4'(bus.dbg_state)}, {1'b1, 4'(S_IF)});
    cyc(); #1;
    check("bad_illegal_clear", 32'(bus.illegal), 32'h0);

    // reset in the middle of a load access
    fetch("rstmid", OP_LW, 6'h00);
    cyc(); cyc(); #1;
    check("rstmid_mrd", 32'(bus.mem_re), 32'h1);
    rst_n = 1'b0;
    cyc(); #1;
    check("rstmid_drop", {20'(outs()), 4'(bus.dbg_state)}, {20'h0, 4'(S_RST)});
    rst_n = 1'b1;
    cyc(); #1;
    check("rstmid_if", {bus.mem_re, 4'(bus.dbg_state)}, {1'b1, 4'(S_IF)});

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
